// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer and the blocks that consume its width.
package pc_seq_pkg;

   localparam int XLEN = 32;
   localparam int unsigned PC_INC = 4;
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and PC bus between decode/execute, the PC sequencer and instruction fetch.
interface pc_sequencer_if #(
   parameter int XLEN = pc_seq_pkg::XLEN
);
   logic            stall;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            halt;
   logic            resume;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_next;
   logic            fetch_valid;
   logic            flush;
   logic            halted;

   modport master (
      output stall, branch_taken, branch_target, halt, resume,
      input  pc_out, pc_next, fetch_valid, flush, halted
   );

   modport slave (
      input  stall, branch_taken, branch_target, halt, resume,
      output pc_out, pc_next, fetch_valid, flush, halted
   );
endinterface

// File: rtl/pc_next_logic.sv
// Combinational priority mux giving the value the PC register loads at the next edge.
module pc_next_logic #(
   parameter int XLEN = pc_seq_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = pc_seq_pkg::RESET_VECTOR,
   parameter int unsigned PC_INC = pc_seq_pkg::PC_INC
) (
   input  logic               rst,
   input  pc_seq_pkg::state_t state,
   input  logic               cnt_zero,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [XLEN-1:0]    branch_target,
   input  logic               halt,
   input  logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    pc_next
);
   import pc_seq_pkg::*;

   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] target_aligned;

   assign pc_inc         = pc + XLEN'(PC_INC);
   assign target_aligned = {branch_target[XLEN-1:2], 2'b00};

   always_comb begin
      pc_next = pc;
      if (rst) begin
         pc_next = RESET_VECTOR;
      end else if (state == HALTED || halt) begin
         pc_next = pc;
      end else if (branch_taken) begin
         pc_next = target_aligned;
      end else begin
         unique case (state)
            RUN:     pc_next = stall ? pc : pc_inc;
            // Leaving the bubble issues the next sequential word, same as leaving reset.
            BUBBLE:  pc_next = (cnt_zero && !stall) ? pc_inc : pc;
            default: pc_next = pc;
         endcase
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, RUN/BUBBLE/HALTED control and fetch qualifiers.
module pc_sequencer #(
   parameter int XLEN = pc_seq_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = pc_seq_pkg::RESET_VECTOR,
   parameter int unsigned PC_INC = pc_seq_pkg::PC_INC,
   parameter int unsigned BRANCH_BUBBLES = 1
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.slave  bus
);
   import pc_seq_pkg::*;

   localparam logic [1:0] BUB_RELOAD =
      (BRANCH_BUBBLES > 0) ? 2'(BRANCH_BUBBLES - 1) : 2'd0;

   state_t          state, state_nx;
   logic [1:0]      cnt, cnt_nx;
   logic            fv_nx, flush_nx;
   logic [XLEN-1:0] pc, pc_nx;

   pc_next_logic #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RESET_VECTOR),
      .PC_INC       (PC_INC)
   ) u_next (
      .rst           (rst),
      .state         (state),
      .cnt_zero      (cnt == 2'd0),
      .stall         (bus.stall),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .halt          (bus.halt),
      .pc            (pc),
      .pc_next       (pc_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= RUN;
         cnt             <= 2'd0;
         pc              <= RESET_VECTOR;
         bus.fetch_valid <= 1'b0;
         bus.flush       <= 1'b0;
         bus.halted      <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         pc              <= pc_nx;
         bus.fetch_valid <= fv_nx;
         bus.flush       <= flush_nx;
         bus.halted      <= (state_nx == HALTED);
      end
   end

   // Priority inside each state: halt > branch_taken > stall > advance.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      fv_nx    = 1'b0;
      flush_nx = 1'b0;
      unique case (state)
         RUN: begin
            if (bus.halt) begin
               state_nx = HALTED;
            end else if (bus.branch_taken) begin
               flush_nx = 1'b1;
               if (BRANCH_BUBBLES > 0) begin
                  state_nx = BUBBLE;
                  cnt_nx   = BUB_RELOAD;
               end else begin
                  fv_nx = 1'b1;
               end
            end else if (!bus.stall) begin
               fv_nx = 1'b1;
            end
         end
         BUBBLE: begin
            if (bus.halt) begin
               state_nx = HALTED;
               cnt_nx   = 2'd0;
            end else if (bus.branch_taken) begin
               flush_nx = 1'b1;
               cnt_nx   = BUB_RELOAD;
            end else if (cnt != 2'd0) begin
               // Stall does not stretch the count; it only gates the final exit.
               cnt_nx = cnt - 2'd1;
            end else if (!bus.stall) begin
               state_nx = RUN;
               fv_nx    = 1'b1;
            end
         end
         HALTED: begin
            if (bus.resume && !bus.halt) begin
               state_nx = RUN;
               fv_nx    = 1'b1;
            end
         end
         default: begin
            state_nx = RUN;
            cnt_nx   = 2'd0;
         end
      endcase
   end

   assign bus.pc_out  = pc;
   assign bus.pc_next = pc_nx;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance with a single-cycle bubble, one with three.
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   pc_sequencer_if #(.XLEN(32)) if1 ();
   pc_sequencer_if #(.XLEN(32)) if3 ();

   pc_sequencer #(
      .XLEN(32), .RESET_VECTOR(32'h0000_0000), .PC_INC(4), .BRANCH_BUBBLES(1)
   ) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   pc_sequencer #(
      .XLEN(32), .RESET_VECTOR(32'h0000_0000), .PC_INC(4), .BRANCH_BUBBLES(3)
   ) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (if3.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic st1(input string tag, input logic [31:0] pc, input logic fv,
                      input logic fl, input logic hl);
      chk({tag, ".pc"},    if1.pc_out,             pc);
      chk({tag, ".fv"},    {31'd0, if1.fetch_valid}, {31'd0, fv});
      chk({tag, ".flush"}, {31'd0, if1.flush},     {31'd0, fl});
      chk({tag, ".halt"},  {31'd0, if1.halted},    {31'd0, hl});
   endtask

   task automatic st3(input string tag, input logic [31:0] pc, input logic fv,
                      input logic fl, input logic hl);
      chk({tag, ".pc"},    if3.pc_out,             pc);
      chk({tag, ".fv"},    {31'd0, if3.fetch_valid}, {31'd0, fv});
      chk({tag, ".flush"}, {31'd0, if3.flush},     {31'd0, fl});
      chk({tag, ".halt"},  {31'd0, if3.halted},    {31'd0, hl});
   endtask

   initial begin
      rst = 1'b1;
      if1.stall = 1'b0; if1.branch_taken = 1'b0; if1.branch_target = '0;
      if1.halt = 1'b0;  if1.resume = 1'b0;
      if3.stall = 1'b0; if3.branch_taken = 1'b0; if3.branch_target = '0;
      if3.halt = 1'b0;  if3.resume = 1'b0;

      // Reset values, then free run
      tick();
      st1("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      st3("reset3", 32'h0, 1'b0, 1'b0, 1'b0);
      chk("reset.pc_next", if1.pc_next, 32'h0);
      rst = 1'b0;
      #1;
      chk("run.pc_next", if1.pc_next, 32'h4);
      for (int i = 1; i <= 4; i++) begin
         tick();
         st1($sformatf("run%0d", i), 32'(4 * i), 1'b1, 1'b0, 1'b0);
      end

      // Branch at pc=8 to an unaligned target
      rst = 1'b1; tick();
      rst = 1'b0; tick(); tick();
      st1("pre_br", 32'h8, 1'b1, 1'b0, 1'b0);
      if1.branch_taken = 1'b1; if1.branch_target = 32'h0000_0103;
      #1;
      chk("br.pc_next", if1.pc_next, 32'h100);
      tick();
      st1("br", 32'h100, 1'b0, 1'b1, 1'b0);
      if1.branch_taken = 1'b0;
      tick();
      st1("br_exit", 32'h104, 1'b1, 1'b0, 1'b0);
      tick();
      st1("br_next", 32'h108, 1'b1, 1'b0, 1'b0);

      // Stall for three cycles at 0x20 with a branch in the second
      if1.branch_taken = 1'b1; if1.branch_target = 32'h0000_001C;
      tick();
      if1.branch_taken = 1'b0;
      tick();
      st1("to20", 32'h20, 1'b1, 1'b0, 1'b0);
      if1.stall = 1'b1;
      tick();
      st1("stall1", 32'h20, 1'b0, 1'b0, 1'b0);
      if1.branch_taken = 1'b1; if1.branch_target = 32'h0000_0200;
      tick();
      st1("stall_br", 32'h200, 1'b0, 1'b1, 1'b0);
      if1.branch_taken = 1'b0;
      tick();
      st1("stall_bub", 32'h200, 1'b0, 1'b0, 1'b0);
      if1.stall = 1'b0;
      tick();
      st1("stall_exit", 32'h204, 1'b1, 1'b0, 1'b0);

      // Halt at 0x40, branch ignored, halt+resume holds, then resume
      if1.branch_taken = 1'b1; if1.branch_target = 32'h0000_003C;
      tick();
      if1.branch_taken = 1'b0;
      tick();
      st1("to40", 32'h40, 1'b1, 1'b0, 1'b0);
      if1.halt = 1'b1;
      tick();
      st1("halt", 32'h40, 1'b0, 1'b0, 1'b1);
      if1.halt = 1'b0; if1.branch_taken = 1'b1; if1.branch_target = 32'h0000_0800;
      if1.stall = 1'b1;
      tick();
      st1("halt_br", 32'h40, 1'b0, 1'b0, 1'b1);
      if1.branch_taken = 1'b0; if1.stall = 1'b0;
      if1.halt = 1'b1; if1.resume = 1'b1;
      tick();
      st1("halt_res", 32'h40, 1'b0, 1'b0, 1'b1);
      if1.halt = 1'b0;
      #1;
      chk("resume.pc_next", if1.pc_next, 32'h40);
      tick();
      st1("resume", 32'h40, 1'b1, 1'b0, 1'b0);
      if1.resume = 1'b0;
      tick();
      st1("resume_inc", 32'h44, 1'b1, 1'b0, 1'b0);

      // Wrap through the top of the address space
      if1.branch_taken = 1'b1; if1.branch_target = 32'hFFFF_FFFF;
      #1;
      chk("wrap.pc_next", if1.pc_next, 32'hFFFF_FFFC);
      tick();
      st1("wrap_br", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
      if1.branch_taken = 1'b0;
      tick();
      st1("wrap", 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      st1("wrap_next", 32'h4, 1'b1, 1'b0, 1'b0);

      // Halt while in the bubble
      if1.branch_taken = 1'b1; if1.branch_target = 32'h0000_0500;
      tick();
      if1.branch_taken = 1'b0; if1.halt = 1'b1;
      tick();
      st1("bub_halt", 32'h500, 1'b0, 1'b0, 1'b1);
      if1.halt = 1'b0; if1.resume = 1'b1;
      tick();
      st1("bub_resume", 32'h500, 1'b1, 1'b0, 1'b0);
      if1.resume = 1'b0;
      tick();
      st1("bub_res_inc", 32'h504, 1'b1, 1'b0, 1'b0);

      // Three-cycle bubble, then reset in the middle of a second one
      if3.branch_taken = 1'b1; if3.branch_target = 32'h0000_0300;
      tick();
      st3("b3_br", 32'h300, 1'b0, 1'b1, 1'b0);
      if3.branch_taken = 1'b0;
      tick();
      st3("b3_bub2", 32'h300, 1'b0, 1'b0, 1'b0);
      tick();
      st3("b3_bub3", 32'h300, 1'b0, 1'b0, 1'b0);
      tick();
      st3("b3_exit", 32'h304, 1'b1, 1'b0, 1'b0);
      if3.branch_taken = 1'b1; if3.branch_target = 32'h0000_0600;
      tick();
      st3("b3_br2", 32'h600, 1'b0, 1'b1, 1'b0);
      if3.branch_taken = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      st3("b3_rst", 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      st3("b3_after", 32'h4, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
